// File: rtl/cpu_pipe_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline: ALUOp/funct codes and the
// bundled control word that travels from ID into EX.
package cpu_pipe_pkg;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ex_ctrl_t;

    localparam int unsigned CTRL_W = $bits(ex_ctrl_t);

    // A bubble must never write the register file or memory.
    localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Pipeline field register: sync reset to zero, sync clear to a fixed value,
// otherwise hold or load. Priority is reset > clear > hold > load.
module pipe_field_reg #(
    parameter int unsigned       Width    = 8,
    parameter logic [Width-1:0]  ClearVal = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hold,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] field_d;
    logic [Width-1:0] field_q;

    always_comb begin
        field_d = field_q;
        if (clear) begin
            field_d = ClearVal;
        end else if (!hold) begin
            field_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            field_q <= '0;
        end else begin
            field_q <= field_d;
        end
    end

    assign q = field_q;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: carries decoded control and operand data into EX,
// with stall (hold) and flush (bubble) support.
module id_ex_pipeline_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_read_data1,
    input  logic [DATA_W-1:0] id_read_data2,
    input  logic [DATA_W-1:0] id_sign_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic [1:0]        ex_alu_op,
    output logic [5:0]        ex_funct,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_read_data1,
    output logic [DATA_W-1:0] ex_read_data2,
    output logic [DATA_W-1:0] ex_sign_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd
);

    localparam int unsigned DataBundleW = 6 + 4 * DATA_W + 3 * REG_W;

    ex_ctrl_t               ctrl_in;
    ex_ctrl_t               ctrl_out;
    logic [CTRL_W-1:0]      ctrl_q;
    logic                   ctrl_clear;
    logic [DataBundleW-1:0] data_in;
    logic [DataBundleW-1:0] data_q;

    always_comb begin
        ctrl_in            = CTRL_BUBBLE;
        ctrl_in.valid      = id_valid;
        ctrl_in.reg_write  = id_reg_write;
        ctrl_in.mem_to_reg = id_mem_to_reg;
        ctrl_in.mem_read   = id_mem_read;
        ctrl_in.mem_write  = id_mem_write;
        ctrl_in.branch     = id_branch;
        ctrl_in.alu_src    = id_alu_src;
        ctrl_in.reg_dst    = id_reg_dst;
        ctrl_in.alu_op     = id_alu_op;
    end

    // An invalid instruction only bubbles the control word when it would
    // actually be loaded; during a stall the resident control must be kept.
    assign ctrl_clear = flush | (~stall & ~id_valid);

    assign data_in = {id_funct, id_pc_plus4, id_read_data1, id_read_data2, id_sign_imm,
                      id_rs, id_rt, id_rd};

    pipe_field_reg #(
        .Width    (CTRL_W),
        .ClearVal (CTRL_BUBBLE)
    ) u_ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .clear (ctrl_clear),
        .hold  (stall),
        .d     (ctrl_in),
        .q     (ctrl_q)
    );

    // Data is zeroed on flush so a stale rs/rt cannot trigger forwarding.
    pipe_field_reg #(
        .Width    (DataBundleW),
        .ClearVal ('0)
    ) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .hold  (stall),
        .d     (data_in),
        .q     (data_q)
    );

    assign ctrl_out = ex_ctrl_t'(ctrl_q);

    assign ex_valid      = ctrl_out.valid;
    assign ex_reg_write  = ctrl_out.reg_write;
    assign ex_mem_to_reg = ctrl_out.mem_to_reg;
    assign ex_mem_read   = ctrl_out.mem_read;
    assign ex_mem_write  = ctrl_out.mem_write;
    assign ex_branch     = ctrl_out.branch;
    assign ex_alu_src    = ctrl_out.alu_src;
    assign ex_reg_dst    = ctrl_out.reg_dst;
    assign ex_alu_op     = ctrl_out.alu_op;

    assign {ex_funct, ex_pc_plus4, ex_read_data1, ex_read_data2, ex_sign_imm,
            ex_rs, ex_rt, ex_rd} = data_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: a reference model pushes the
// expected EX bundle per edge, which is popped and compared after the edge.
module tb_id_ex_pipeline_reg;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        alu_src;
        logic        reg_dst;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } fld_t;

    localparam int unsigned FW = $bits(fld_t);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    fld_t id_s = '0;
    fld_t model_q = '0;
    fld_t got;
    fld_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_alu_src, ex_reg_dst;
    logic [1:0]  ex_alu_op;
    logic [5:0]  ex_funct;
    logic [31:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_sign_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(
        .DATA_W (32),
        .REG_W  (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .id_valid      (id_s.valid),
        .id_reg_write  (id_s.reg_write),
        .id_mem_to_reg (id_s.mem_to_reg),
        .id_mem_read   (id_s.mem_read),
        .id_mem_write  (id_s.mem_write),
        .id_branch     (id_s.branch),
        .id_alu_src    (id_s.alu_src),
        .id_reg_dst    (id_s.reg_dst),
        .id_alu_op     (id_s.alu_op),
        .id_funct      (id_s.funct),
        .id_pc_plus4   (id_s.pc),
        .id_read_data1 (id_s.rd1),
        .id_read_data2 (id_s.rd2),
        .id_sign_imm   (id_s.imm),
        .id_rs         (id_s.rs),
        .id_rt         (id_s.rt),
        .id_rd         (id_s.rd),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_branch     (ex_branch),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_op     (ex_alu_op),
        .ex_funct      (ex_funct),
        .ex_pc_plus4   (ex_pc_plus4),
        .ex_read_data1 (ex_read_data1),
        .ex_read_data2 (ex_read_data2),
        .ex_sign_imm   (ex_sign_imm),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd)
    );

    assign got = {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch,
                  ex_alu_src, ex_reg_dst, ex_alu_op, ex_funct, ex_pc_plus4, ex_read_data1,
                  ex_read_data2, ex_sign_imm, ex_rs, ex_rt, ex_rd};

    task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Drive one edge: update the model, push its prediction, compare after the edge.
    task automatic step(input string tag, input logic rst, input logic stl, input logic fls);
        fld_t e;
        reset = rst;
        stall = stl;
        flush = fls;
        if (rst || fls) begin
            model_q = '0;
        end else if (!stl) begin
            model_q = id_s;
            if (!id_s.valid) begin
                model_q.reg_write  = 1'b0;
                model_q.mem_to_reg = 1'b0;
                model_q.mem_read   = 1'b0;
                model_q.mem_write  = 1'b0;
                model_q.branch     = 1'b0;
                model_q.alu_src    = 1'b0;
                model_q.reg_dst    = 1'b0;
                model_q.alu_op     = 2'b00;
            end
        end
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, got, e);
        end
    endtask

    task automatic rand_id();
        id_s = fld_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    endtask

    initial begin
        // Reset then R-type ADD
        id_s = '0;
        step("rst0", 1'b1, 1'b0, 1'b0);
        check_eq("rst0_zero", got, '0);
        step("rst1", 1'b1, 1'b0, 1'b0);
        id_s = '{valid: 1'b1, reg_write: 1'b1, reg_dst: 1'b1, alu_op: 2'b10,
                 funct: 6'b100000, rs: 5'd8, rt: 5'd9, rd: 5'd10, rd1: 32'd5, rd2: 32'd7,
                 pc: 32'h0000_0104, default: '0};
        step("add", 1'b0, 1'b0, 1'b0);
        check_eq("add_rd", FW'(ex_rd), FW'(10));
        check_eq("add_valid", FW'(ex_valid), FW'(1));

        // LW then 3-cycle stall with changing ID inputs
        id_s = '{valid: 1'b1, reg_write: 1'b1, mem_to_reg: 1'b1, mem_read: 1'b1,
                 alu_src: 1'b1, alu_op: 2'b00, imm: 32'h0000_0004, rs: 5'd29, rt: 5'd4,
                 default: '0};
        step("lw", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rand_id();
            id_s.valid = 1'b1;
            step("lw_stall", 1'b0, 1'b1, 1'b0);
        end
        check_eq("lw_hold_imm", FW'(ex_sign_imm), FW'(4));
        check_eq("lw_hold_mr", FW'(ex_mem_read), FW'(1));

        // BEQ resident, then flush
        id_s = '{valid: 1'b1, branch: 1'b1, alu_op: 2'b01, rs: 5'd3, rt: 5'd5,
                 funct: 6'b100010, default: '0};
        step("beq", 1'b0, 1'b0, 1'b0);
        rand_id();
        id_s.valid = 1'b1;
        step("beq_flush", 1'b0, 1'b0, 1'b1);
        check_eq("flush_rs_rt", FW'({ex_rs, ex_rt}), FW'(0));
        check_eq("flush_aluop", FW'(ex_alu_op), FW'(0));

        // SW resident, stall and flush together
        id_s = '{valid: 1'b1, mem_write: 1'b1, alu_src: 1'b1, rs: 5'd2, rt: 5'd6,
                 imm: 32'h0000_0010, default: '0};
        step("sw", 1'b0, 1'b0, 1'b0);
        step("sw_stall_flush", 1'b0, 1'b1, 1'b1);
        check_eq("sf_mem_write", FW'({ex_mem_write, ex_valid}), FW'(0));

        // Invalid instruction with write enables set
        id_s = '{valid: 1'b0, reg_write: 1'b1, mem_write: 1'b1, alu_op: 2'b10,
                 rs: 5'd1, rt: 5'd2, default: '0};
        step("invalid", 1'b0, 1'b0, 1'b0);
        check_eq("inv_writes", FW'({ex_reg_write, ex_mem_write, ex_valid}), FW'(0));

        // SUB held by stall, reset mid-stall, then resume
        id_s = '{valid: 1'b1, reg_write: 1'b1, reg_dst: 1'b1, alu_op: 2'b10,
                 funct: 6'b100010, rs: 5'd11, rt: 5'd12, rd: 5'd13, default: '0};
        step("sub", 1'b0, 1'b0, 1'b0);
        step("sub_stall", 1'b0, 1'b1, 1'b0);
        check_eq("sub_funct", FW'(ex_funct), FW'(6'b100010));
        step("mid_reset", 1'b1, 1'b1, 1'b0);
        check_eq("mid_reset_zero", got, '0);
        id_s = '{valid: 1'b1, reg_write: 1'b1, alu_op: 2'b11, funct: 6'b101010,
                 rs: 5'd7, rt: 5'd8, rd: 5'd9, default: '0};
        step("resume", 1'b0, 1'b0, 1'b0);
        check_eq("resume_aluop11", FW'(ex_alu_op), FW'(2'b11));

        // Random traffic including invalid loads under stall
        for (int i = 0; i < 40; i++) begin
            rand_id();
            step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
